// File: rtl/ide_pio_seq.sv
// ide_pio_seq -- PIO bus-cycle sequencer for an IDE/ATA drive port.
//
// Turns one host bus request (ide_req) into a chip-select / strobe sequence:
// IDLE -> SETUP -> STROBE -> HOLD -> ACK -> IDLE.
// Every drive-facing output is a flop loaded from the next-state decode, so
// each output changes on the same edge as the state it belongs to.
//
// Optional feature: define IDE_IORDY_EN to let the drive stretch the strobe
// with IORDY. An 8-bit watchdog limits the stretch to 255 extra cycles.
// Without the macro, IORDY is ignored and no watchdog logic is built.

module ide_pio_seq #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ide_req,
    input  logic RW,
    input  logic ADDR12,
    input  logic IORDY,
    output logic IDECS1_n,
    output logic IDECS2_n,
    output logic IOR_n,
    output logic IOW_n,
    output logic DTACK,
    output logic busy
);

    // Phase lengths must fit the 4-bit down-counter and may not be zero.
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("ide_pio_seq: SETUP_CYC must be in 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("ide_pio_seq: STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("ide_pio_seq: HOLD_CYC must be in 1..15");
    end

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    logic [2:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       rw_reg, rw_next;       // 1 = read cycle
    logic       bank_reg, bank_next;   // 0 = IDECS1_n, 1 = IDECS2_n

    logic [1:0] cs_n_reg;              // index = bank
    logic       ior_n_reg, iow_n_reg, dtack_reg;

    logic       cs_active_next;
    logic       strobe_active_next;

`ifdef IDE_IORDY_EN
    logic [7:0] wait_reg, wait_next;   // extra STROBE cycles spent waiting on IORDY
`else
    logic       iordy_unused;
    assign iordy_unused = IORDY;
`endif

    // Next-state, counter and latched cycle attributes.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rw_next    = rw_reg;
        bank_next  = bank_reg;
`ifdef IDE_IORDY_EN
        wait_next  = wait_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ide_req) begin
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LOAD;
                    rw_next    = RW;
                    bank_next  = ADDR12;
                end
            end
            ST_SETUP: begin
                if (!ide_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ST_STROBE;
                    cnt_next   = STROBE_LOAD;
`ifdef IDE_IORDY_EN
                    wait_next  = 8'd0;
`endif
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_STROBE: begin
                if (!ide_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
`ifdef IDE_IORDY_EN
                end else if (!IORDY && wait_reg != 8'hFF) begin
                    // Drive not ready: hold the strobe low, bounded by the watchdog.
                    wait_next = wait_reg + 8'd1;
`endif
                end else begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!ide_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACK: begin
                // Held high here never re-triggers: a new cycle needs IDLE first.
                if (!ide_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output decode of the state being entered, so outputs are registered
    // yet aligned with the state register.
    always_comb begin
        cs_active_next     = (state_next == ST_SETUP) ||
                             (state_next == ST_STROBE) ||
                             (state_next == ST_HOLD);
        strobe_active_next = (state_next == ST_STROBE);
    end

    // Sequencer state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            rw_reg    <= 1'b1;
            bank_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rw_reg    <= rw_next;
            bank_reg  <= bank_next;
        end
    end

`ifdef IDE_IORDY_EN
    // IORDY wait watchdog.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_reg <= 8'd0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`endif

    // One chip-select flop per register bank; only the latched bank goes low.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cs
        // Chip-select for bank gi.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                cs_n_reg[gi] <= 1'b1;
            end else begin
                cs_n_reg[gi] <= !(cs_active_next && (bank_next == 1'(gi)));
            end
        end
    end

    // Read/write strobes and bus acknowledge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ior_n_reg <= 1'b1;
            iow_n_reg <= 1'b1;
            dtack_reg <= 1'b0;
        end else begin
            ior_n_reg <= !(strobe_active_next && rw_next);
            iow_n_reg <= !(strobe_active_next && !rw_next);
            dtack_reg <= (state_next == ST_ACK);
        end
    end

    assign IDECS1_n = cs_n_reg[0];
    assign IDECS2_n = cs_n_reg[1];
    assign IOR_n    = ior_n_reg;
    assign IOW_n    = iow_n_reg;
    assign DTACK    = dtack_reg;
    assign busy     = (state_reg != ST_IDLE);

    // Drive-side safety properties: never two selects, never both strobes,
    // never a strobe without its select.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (cs_n_reg != 2'b00);
            assert (ior_n_reg || iow_n_reg);
            assert ((ior_n_reg && iow_n_reg) || (cs_n_reg != 2'b11));
        end
    end

endmodule

// File: tb/tb_ide_pio_seq.sv
// tb_ide_pio_seq -- directed bench for ide_pio_seq.
// Two instances: u_def with default timing, u_wr with SETUP=2/STROBE=3/HOLD=2.
// Edge numbering: requests are driven just after edge 0, so the sequencer
// first sees them at edge 1. Outputs are sampled 1 ns after each edge.
// Observed vector order: {IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, busy}.

module tb_ide_pio_seq;

    logic clk = 1'b0;
    logic rst;
    logic req_a, req_b;
    logic rw, addr12, iordy;

    logic cs1_a, cs2_a, ior_a, iow_a, dtack_a, busy_a;
    logic cs1_b, cs2_b, ior_b, iow_b, dtack_b, busy_b;
    logic [5:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] IDLE_VEC = 6'b111100;

    always #5 clk = ~clk;

    assign obs_a = {cs1_a, cs2_a, ior_a, iow_a, dtack_a, busy_a};
    assign obs_b = {cs1_b, cs2_b, ior_b, iow_b, dtack_b, busy_b};

    ide_pio_seq u_def (
        .CLK      (clk),
        .RESET    (rst),
        .ide_req  (req_a),
        .RW       (rw),
        .ADDR12   (addr12),
        .IORDY    (iordy),
        .IDECS1_n (cs1_a),
        .IDECS2_n (cs2_a),
        .IOR_n    (ior_a),
        .IOW_n    (iow_a),
        .DTACK    (dtack_a),
        .busy     (busy_a)
    );

    ide_pio_seq #(
        .SETUP_CYC  (2),
        .STROBE_CYC (3),
        .HOLD_CYC   (2)
    ) u_wr (
        .CLK      (clk),
        .RESET    (rst),
        .ide_req  (req_b),
        .RW       (rw),
        .ADDR12   (addr12),
        .IORDY    (iordy),
        .IDECS1_n (cs1_b),
        .IDECS2_n (cs2_b),
        .IOR_n    (ior_b),
        .IOW_n    (iow_b),
        .DTACK    (dtack_b),
        .busy     (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset forces idle even with requests pending; first cycle may start
    // on the edge after reset is released.
    task automatic test_reset();
        rw = 1'b1; addr12 = 1'b0; iordy = 1'b1;
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_a !== IDLE_VEC) begin
                errors++;
                $display("FAIL rst_hold_a cycle %0d: got %b want %b", i, obs_a, IDLE_VEC);
            end
            checks++;
            if (obs_b !== IDLE_VEC) begin
                errors++;
                $display("FAIL rst_hold_b cycle %0d: got %b want %b", i, obs_b, IDLE_VEC);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs_a !== 6'b011101) begin
            errors++;
            $display("FAIL rst_release_start_a: got %b want %b", obs_a, 6'b011101);
        end
        checks++;
        if (obs_b !== 6'b011101) begin
            errors++;
            $display("FAIL rst_release_start_b: got %b want %b", obs_b, 6'b011101);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        checks++;
        if ({obs_a, obs_b} !== {IDLE_VEC, IDLE_VEC}) begin
            errors++;
            $display("FAIL rst_setup_abort: got %b/%b want %b", obs_a, obs_b, IDLE_VEC);
        end
        $display("reset transaction done");
    endtask

    // Default read from bank 0; RW/ADDR12 are flipped mid-cycle and must not matter.
    task automatic test_read_default();
        logic [5:0] exp;
        rw = 1'b1; addr12 = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {!(e >= 1 && e <= 4), 1'b1, !(e >= 2 && e <= 3), 1'b1,
                   (e >= 5 && e <= 6), (e <= 6)};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL read_default edge %0d: got %b want %b", e, obs_a, exp);
            end
            if (e == 2) begin rw = 1'b0; addr12 = 1'b1; end
            if (e == 6) req_a = 1'b0;
        end
        rw = 1'b1; addr12 = 1'b0;
        $display("read transaction done (default timing, bank 0)");
    endtask

    // Write to bank 1 with SETUP=2/STROBE=3/HOLD=2.
    task automatic test_write_custom();
        logic [5:0] exp;
        rw = 1'b0; addr12 = 1'b1; req_b = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {1'b1, !(e >= 1 && e <= 7), 1'b1, !(e >= 3 && e <= 5),
                   (e >= 8 && e <= 9), (e <= 9)};
            checks++;
            if (obs_b !== exp) begin
                errors++;
                $display("FAIL write_custom edge %0d: got %b want %b", e, obs_b, exp);
            end
            if (e == 9) req_b = 1'b0;
        end
        rw = 1'b1; addr12 = 1'b0;
        $display("write transaction done (2/3/2 timing, bank 1)");
    endtask

    // Request withdrawn during STROBE: everything inactive on the next edge.
    task automatic test_abort();
        logic [5:0] exp;
        rw = 1'b1; addr12 = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 1) ? 6'b011101 : (e == 2) ? 6'b010101 : IDLE_VEC;
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL abort_strobe edge %0d: got %b want %b", e, obs_a, exp);
            end
            if (e == 2) req_a = 1'b0;
        end
        $display("aborted read transaction done");
    endtask

    // Request held through ACK gives one cycle only; a one-cycle drop then
    // re-raise starts a second cycle.
    task automatic test_back_to_back();
        logic [5:0] exp;
        logic cs_lo, ior_lo, dt, bz;
        rw = 1'b1; addr12 = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            cs_lo  = (e >= 1 && e <= 4) || (e >= 12 && e <= 15);
            ior_lo = (e >= 2 && e <= 3) || (e >= 13 && e <= 14);
            dt     = (e >= 5 && e <= 10) || (e >= 16 && e <= 17);
            bz     = (e <= 10) || (e >= 12 && e <= 17);
            exp = {!cs_lo, 1'b1, !ior_lo, 1'b1, dt, bz};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL back_to_back edge %0d: got %b want %b", e, obs_a, exp);
            end
            if (e == 10) req_a = 1'b0;
            if (e == 11) req_a = 1'b1;
            if (e == 17) req_a = 1'b0;
        end
        $display("back-to-back transactions done");
    endtask

`ifdef IDE_IORDY_EN
    // IORDY low for 4 extra cycles stretches the strobe to 6 cycles.
    task automatic test_iordy_stretch();
        logic [5:0] exp;
        rw = 1'b1; addr12 = 1'b0; iordy = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp = {!(e >= 1 && e <= 8), 1'b1, !(e >= 2 && e <= 7), 1'b1,
                   (e >= 9 && e <= 10), (e <= 10)};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL iordy_stretch edge %0d: got %b want %b", e, obs_a, exp);
            end
            if (e == 7) iordy = 1'b1;
            if (e == 10) req_a = 1'b0;
        end
        $display("IORDY-stretched read transaction done");
    endtask

    // IORDY stuck low: watchdog forces HOLD after 255 extra cycles.
    task automatic test_iordy_timeout();
        logic [5:0] exp;
        rw = 1'b1; addr12 = 1'b0; iordy = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 262; e++) begin
            tick();
            exp = {!(e <= 259), 1'b1, !(e >= 2 && e <= 258), 1'b1,
                   (e >= 260 && e <= 261), (e <= 261)};
            if (e <= 3 || e >= 256) begin
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("FAIL iordy_timeout edge %0d: got %b want %b", e, obs_a, exp);
                end
            end
            if (e == 261) req_a = 1'b0;
        end
        iordy = 1'b1;
        $display("IORDY timeout read transaction done");
    endtask
`else
    // IORDY held low must be ignored: timing identical to the default read.
    task automatic test_iordy_ignored();
        logic [5:0] exp;
        rw = 1'b1; addr12 = 1'b0; iordy = 1'b0; req_a = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp = {!(e >= 1 && e <= 4), 1'b1, !(e >= 2 && e <= 3), 1'b1,
                   (e >= 5 && e <= 6), (e <= 6)};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL iordy_ignored edge %0d: got %b want %b", e, obs_a, exp);
            end
            if (e == 6) req_a = 1'b0;
        end
        iordy = 1'b1;
        $display("read transaction with IORDY low done");
    endtask
`endif

    // Reset asserted for two cycles while in STROBE.
    task automatic test_reset_mid_strobe();
        rw = 1'b1; addr12 = 1'b0; req_a = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_a !== 6'b010101) begin
            errors++;
            $display("FAIL midrst_in_strobe: got %b want %b", obs_a, 6'b010101);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_a !== IDLE_VEC) begin
                errors++;
                $display("FAIL midrst_cycle %0d: got %b want %b", i, obs_a, IDLE_VEC);
            end
        end
        rst = 1'b0; req_a = 1'b0;
        tick();
        checks++;
        if (obs_a !== IDLE_VEC) begin
            errors++;
            $display("FAIL midrst_after: got %b want %b", obs_a, IDLE_VEC);
        end
        $display("reset during strobe transaction done");
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        rw = 1'b1; addr12 = 1'b0; iordy = 1'b1;
        tick();
        test_reset();
        test_read_default();
        test_write_custom();
        test_abort();
        test_back_to_back();
`ifdef IDE_IORDY_EN
        test_iordy_stretch();
        test_iordy_timeout();
`else
        test_iordy_ignored();
`endif
        test_reset_mid_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ide_pio_seq.md
IDE_PIO_SEQ -- requirements
Module: ide_pio_seq

Interface
REQ-001 Parameter SETUP_CYC, default 1: CLK cycles chip-select is asserted before the strobe (1-15).
REQ-002 Parameter STROBE_CYC, default 2: minimum CLK cycles IOR_n/IOW_n is low (1-15).
REQ-003 Parameter HOLD_CYC, default 1: CLK cycles chip-select is held after the strobe rises (1-15).
REQ-004 CLK  input  1  7 MHz bus clock; all state changes on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 ide_req  input  1  IDE window decoded and AS_n asserted; high for the whole bus cycle.
REQ-007 RW  input  1  1 = read (IOR_n), 0 = write (IOW_n); sampled when leaving IDLE.
REQ-008 ADDR12  input  1  register bank select: 0 = IDECS1_n, 1 = IDECS2_n; sampled when leaving IDLE.
REQ-009 IORDY  input  1  drive ready; used only when IDE_IORDY_EN is defined.
REQ-010 IDECS1_n, IDECS2_n  output  1 each  registered drive chip-selects, active low.
REQ-011 IOR_n, IOW_n  output  1 each  registered drive strobes, active low.
REQ-012 DTACK  output  1  registered, active high; bus cycle may complete.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, SETUP, STROBE, HOLD, ACK; encoded in a registered state vector.
REQ-015 IDLE: all chip-selects/strobes high, DTACK low; ide_req high -> SETUP, latch RW and ADDR12, load counter with SETUP_CYC-1.
REQ-016 SETUP: selected IDECSx_n low; counter decrements each cycle; at 0 -> STROBE, load STROBE_CYC-1.
REQ-017 STROBE: selected CS low, IOR_n low (read) or IOW_n low (write), never both; at count 0 -> HOLD, load HOLD_CYC-1.
REQ-018 HOLD: strobes high, selected CS low; at count 0 -> ACK.
REQ-019 ACK: all chip-selects/strobes high, DTACK high; remain until ide_req low, then IDLE with DTACK low next edge.
REQ-020 Latency: with ide_req rising before edge 0, CS falls after edge 1, strobe falls after edge 1+SETUP_CYC, DTACK rises after edge 1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
REQ-021 Defaults give CS low 4 cycles, strobe low 2 cycles (~282 ns), DTACK at edge 5.
REQ-022 Abort: ide_req low in SETUP, STROBE or HOLD -> IDLE at next edge, all outputs inactive that edge.
REQ-023 Back-to-back: ide_req must be seen low for at least one cycle (ACK->IDLE) before a new cycle starts; ide_req held high in ACK never re-triggers.
REQ-024 Counter is 4 bits; no wrap-around permitted; parameters of 0 are illegal and flagged by a synthesis-time check.
REQ-025 Only one of IDECS1_n/IDECS2_n is ever low; RW/ADDR12 changes after IDLE exit have no effect.

Reset
REQ-026 RESET high at a rising edge forces IDLE, counter 0, IDECS1_n=IDECS2_n=IOR_n=IOW_n=1, DTACK=0, busy=0, regardless of state.
REQ-027 RESET overrides ide_req and IORDY; first cycle may start on the edge after RESET falls.

Configuration
REQ-028 Macro IDE_IORDY_EN defined: in STROBE with count 0 and IORDY low, remain in STROBE (strobe held low) until IORDY high, then HOLD; an 8-bit timeout of 255 extra cycles forces HOLD.
REQ-029 Macro IDE_IORDY_EN undefined: IORDY ignored, STROBE length exactly STROBE_CYC; no timeout logic synthesized.

Verification
REQ-030 Reset: RESET high 2 cycles mid-STROBE -> next edge all strobes/CS high, DTACK 0, busy 0.
REQ-031 Default read, ADDR12=0: ide_req high at edge 0 -> IDECS1_n low edges 1-4, IOR_n low edges 2-3, IOW_n high, DTACK high from edge 5 until one edge after ide_req falls.
REQ-032 Write, ADDR12=1, SETUP=2/STROBE=3/HOLD=2: IDECS2_n low 7 cycles, IOW_n low 3 cycles, DTACK at edge 8.
REQ-033 Abort: ide_req falls during STROBE -> IOR_n and CS high at next edge, DTACK never asserted, state IDLE.
REQ-034 IDE_IORDY_EN: IORDY low 4 extra cycles -> IOR_n low 6 cycles, DTACK delayed 4; IORDY stuck low -> HOLD after 255 extra cycles.
REQ-035 Back-to-back: ide_req held high through ACK -> single cycle only; drop 1 cycle, raise -> second cycle CS falls one edge later.
